random_choose_n: RTL and testbench

- Parametrised successor to the 4-way weighted random segment chooser.
- Picks one of NUM_SEG segments with probability weight[i]/sum(weights).
- Two modes:
  - Random: Galois LFSR draw.
  - Deterministic: cycling counter, giving exact proportions per period.
- Valid/ready result handshake. Sits between the configurator's traffic generator and the address-segment mapper.

---
 rtl/random_choose_n_pkg.sv | 19 +
 rtl/random_choose_n_lfsr.sv | 28 ++
 rtl/random_choose_n.sv | 179 +++++++++++++++++
 tb/tb_random_choose_n.sv | 517 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/random_choose_n_pkg.sv
// Shared types and constants for the weighted random segment chooser.
package random_choose_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAW  = 3'd2,
    ST_SCAN  = 3'd3,
    ST_VALID = 3'd4
  } state_t;

  localparam logic [31:0] LFSR_POLY_DEFAULT = 32'h8020_0003;

  // Segment index width; a single segment still needs one bit.
  function automatic int seg_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/random_choose_n_lfsr.sv
// Galois LFSR, right-shifting. A zero seed is replaced by 1 so the
// register can never lock up in the all-zero state.
module lfsr_galois
  import random_choose_pkg::*;
#(
  parameter int                LFSR_W    = 32,
  parameter logic [LFSR_W-1:0] LFSR_POLY = LFSR_W'(LFSR_POLY_DEFAULT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] value
);

  // Seed load wins over stepping; stepping only while enabled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= LFSR_W'(1);
    end else if (load) begin
      value <= (seed == '0) ? LFSR_W'(1) : seed;
    end else if (enable) begin
      value <= value[0] ? ((value >> 1) ^ LFSR_POLY) : (value >> 1);
    end
  end

endmodule

// File: rtl/random_choose_n.sv
// Weighted segment chooser: picks segment i with probability
// weight[i]/sum(weights), either from an LFSR fraction or from a
// cycling counter that hits every slot of the weight period exactly once.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for in_enable
// LOAD  | snapshot weights and their total
// DRAW  | pick draw value r in 0..total-1 (random or counter)
// SCAN  | walk segments, one per cycle, until r < running sum
// VALID | hold result until the consumer takes it
module random_choose_n
  import random_choose_pkg::*;
#(
  parameter int                NUM_SEG   = 4,
  parameter int                SEG_W     = seg_w(NUM_SEG),
  parameter int                WEIGHT_W  = 13,
  parameter int                TOT_W     = WEIGHT_W + SEG_W,
  parameter int                LFSR_W    = 32,
  parameter logic [LFSR_W-1:0] LFSR_POLY = LFSR_W'(LFSR_POLY_DEFAULT),
  parameter int                FRAC_W    = 16
) (
  input  logic                        in_clock,
  input  logic                        in_reset,
  input  logic                        in_enable,
  input  logic                        in_mode,
  input  logic                        in_seed_load,
  input  logic [LFSR_W-1:0]           in_seed,
  input  logic [NUM_SEG*WEIGHT_W-1:0] in_weights,
  input  logic                        in_ready,
  output logic                        out_valid,
  output logic [SEG_W-1:0]            out_segment_number,
  output logic                        out_none,
  output logic                        out_busy
);

  state_t state_q, state_d;

  logic [LFSR_W-1:0]   lfsr_value;
  logic [LFSR_W-1:0]   unused_lfsr;
  logic [WEIGHT_W-1:0] w_in   [NUM_SEG];
  logic [WEIGHT_W-1:0] w_snap [NUM_SEG];
  logic [TOT_W-1:0]    total_in, total_q;
  logic [TOT_W-1:0]    det_cnt, draw_r, acc_q, acc_n, rand_r;
  logic [SEG_W-1:0]    idx_q;
  logic [FRAC_W+TOT_W-1:0] prod;
  logic                scan_hit;

  lfsr_galois #(
    .LFSR_W    (LFSR_W),
    .LFSR_POLY (LFSR_POLY)
  ) u_lfsr (
    .clock  (in_clock),
    .reset  (in_reset),
    .enable (in_enable),
    .load   (in_seed_load),
    .seed   (in_seed),
    .value  (lfsr_value)
  );

  // Only the low FRAC_W bits feed the draw; the rest just keep the sequence long.
  assign unused_lfsr = lfsr_value;

  // Unpack the flat weight bus and form its total.
  always_comb begin
    total_in = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      w_in[i]  = in_weights[i*WEIGHT_W +: WEIGHT_W];
      total_in = total_in + TOT_W'(w_in[i]);
    end
  end

  // Random draw: scale the LFSR fraction onto 0..total-1.
  always_comb begin
    prod   = {{TOT_W{1'b0}}, lfsr_value[FRAC_W-1:0]} * {{FRAC_W{1'b0}}, total_q};
    rand_r = prod[FRAC_W +: TOT_W];
  end

  // Running sum for the segment under inspection; the last segment always
  // terminates the scan so a corrupted draw cannot hang the FSM.
  always_comb begin
    acc_n    = acc_q + TOT_W'(w_snap[idx_q]);
    scan_hit = (draw_r < acc_n) || (idx_q == SEG_W'(NUM_SEG - 1));
  end

  assign out_busy = (state_q != ST_IDLE);

  // State register.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a result hand-off is honoured even while disabled.
  always_comb begin
    state_d = state_q;
    if (in_seed_load) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (in_enable) state_d = ST_LOAD;
        ST_LOAD:  if (in_enable) state_d = (total_in == '0) ? ST_VALID : ST_DRAW;
        ST_DRAW:  if (in_enable) state_d = ST_SCAN;
        ST_SCAN:  if (in_enable && scan_hit) state_d = ST_VALID;
        ST_VALID: if (in_ready) state_d = in_enable ? ST_LOAD : ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath: snapshot, draw, scan and result registers.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      for (int i = 0; i < NUM_SEG; i++) w_snap[i] <= '0;
      total_q            <= '0;
      det_cnt            <= '0;
      draw_r             <= '0;
      acc_q              <= '0;
      idx_q              <= '0;
      out_valid          <= 1'b0;
      out_segment_number <= '0;
      out_none           <= 1'b0;
    end else if (in_seed_load) begin
      det_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_enable) begin
            w_snap  <= w_in;
            total_q <= total_in;
            if (total_in == '0) begin
              out_valid          <= 1'b1;
              out_none           <= 1'b1;
              out_segment_number <= '0;
            end else begin
              out_none <= 1'b0;
            end
          end
        end
        ST_DRAW: begin
          if (in_enable) begin
            idx_q <= '0;
            acc_q <= '0;
            if (!in_mode) begin
              draw_r <= rand_r;
            end else if (det_cnt >= total_q) begin
              // Weights shrank below the counter: restart the period at slot 0.
              draw_r  <= '0;
              det_cnt <= (total_q == TOT_W'(1)) ? '0 : TOT_W'(1);
            end else begin
              draw_r  <= det_cnt;
              det_cnt <= (det_cnt + TOT_W'(1) == total_q) ? '0 : det_cnt + TOT_W'(1);
            end
          end
        end
        ST_SCAN: begin
          if (in_enable) begin
            if (scan_hit) begin
              out_segment_number <= idx_q;
              out_valid          <= 1'b1;
            end else begin
              idx_q <= idx_q + SEG_W'(1);
              acc_q <= acc_n;
            end
          end
        end
        ST_VALID: begin
          if (in_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_random_choose_n.sv
// Bench for random_choose_n: results are predicted from the weight
// proportions (cumulative-sum lookup) and a software LFSR sequence.
module tb_random_choose_n;

  localparam int NS = 4;
  localparam int WW = 13;

  logic           in_clock;
  logic           in_reset;
  logic           in_enable;
  logic           in_mode;
  logic           in_seed_load;
  logic [31:0]    in_seed;
  logic [NS*WW-1:0] in_weights;
  logic           in_ready;
  logic           out_valid;
  logic [1:0]     out_segment_number;
  logic           out_none;
  logic           out_busy;

  int n_tests = 0;
  int n_fail  = 0;

  int          mw[NS];
  logic [31:0] m_lfsr = 32'd1;
  int          det_p  = 0;
  int          seq[8000];

  random_choose_n dut (
    .in_clock           (in_clock),
    .in_reset           (in_reset),
    .in_enable          (in_enable),
    .in_mode            (in_mode),
    .in_seed_load       (in_seed_load),
    .in_seed            (in_seed),
    .in_weights         (in_weights),
    .in_ready           (in_ready),
    .out_valid          (out_valid),
    .out_segment_number (out_segment_number),
    .out_none           (out_none),
    .out_busy           (out_busy)
  );

  initial begin
    in_clock = 1'b0;
    forever #5 in_clock = ~in_clock;
  end

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  function automatic int model_total();
    int t = 0;
    for (int i = 0; i < NS; i++) t += mw[i];
    return t;
  endfunction

  // Segment owning slot r of the weight period.
  function automatic int seg_of(input int r);
    int cum = 0;
    for (int i = 0; i < NS; i++) begin
      cum += mw[i];
      if (r < cum) return i;
    end
    return NS - 1;
  endfunction

  function automatic int rand_seg(input logic [31:0] l);
    longint f = longint'(l[15:0]);
    return seg_of(int'((f * longint'(model_total())) >> 16));
  endfunction

  task automatic det_expect(output int seg);
    int t = model_total();
    int r;
    if (det_p >= t) begin
      r = 0;
      det_p = (t == 1) ? 0 : 1;
    end else begin
      r = det_p;
      det_p = (det_p + 1 == t) ? 0 : det_p + 1;
    end
    seg = seg_of(r);
  endtask

  // One clock edge; the software LFSR follows the load/step rules.
  task automatic tick();
    @(posedge in_clock);
    if (in_seed_load) m_lfsr = (in_seed == 32'd0) ? 32'd1 : in_seed;
    else if (in_enable) m_lfsr = lfsr_next(m_lfsr);
    #1;
  endtask

  task automatic set_weights(input int a, input int b, input int c, input int d);
    mw[0] = a; mw[1] = b; mw[2] = c; mw[3] = d;
    in_weights = {13'(d), 13'(c), 13'(b), 13'(a)};
  endtask

  task automatic seed_load(input logic [31:0] s);
    in_enable    = 1'b0;
    in_seed      = s;
    in_seed_load = 1'b1;
    tick();
    in_seed_load = 1'b0;
    det_p        = 0;
  endtask

  // Advance until out_valid; lat counts edges, draw_l is the LFSR value the draw uses.
  task automatic wait_valid(output int lat, output logic [31:0] draw_l, output bit to);
    lat    = 0;
    draw_l = m_lfsr;
    do begin
      tick();
      lat++;
      if (lat == 2) draw_l = m_lfsr;
    end while (!out_valid && lat < 60);
    to = !out_valid;
  endtask

  task automatic test_reset();
    in_reset = 1'b0; in_enable = 1'b0; in_mode = 1'b0; in_seed_load = 1'b0;
    in_seed = '0; in_ready = 1'b0;
    set_weights(0, 0, 0, 0);
    #2;
    n_tests++;
    if ({out_valid, out_segment_number, out_none, out_busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%0b seg=%0d none=%0b busy=%0b expected all 0",
               out_valid, out_segment_number, out_none, out_busy);
    end
    tick(); tick();
    in_reset = 1'b1;
    m_lfsr   = 32'd1;
    tick();
    n_tests++;
    if (out_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %0b expected 0", out_busy);
    end
  endtask

  task automatic test_deterministic();
    int lat, exp;
    logic [31:0] dl;
    bit to;
    set_weights(2, 4, 2, 0);
    in_mode = 1'b1; in_ready = 1'b1;
    seed_load(32'd7);
    in_enable = 1'b1;
    for (int n = 0; n < 16; n++) begin
      wait_valid(lat, dl, to);
      det_expect(exp);
      n_tests++;
      if (to || out_segment_number !== 2'(exp) || out_none !== 1'b0) begin
        n_fail++;
        $display("FAIL det_seg[%0d]: got %0d (timeout=%0b none=%0b) expected %0d",
                 n, out_segment_number, to, out_none, exp);
      end
      n_tests++;
      if (lat - 1 != exp + 3) begin
        n_fail++;
        $display("FAIL det_latency[%0d]: got %0d edges expected %0d", n, lat - 1, exp + 3);
      end
    end
  endtask

  // Weight changes between draws, including a total below the running counter.
  task automatic test_det_weights();
    int lat, exp, t;
    logic [31:0] dl;
    bit to;
    set_weights(2, 4, 2, 0);
    in_mode = 1'b1; in_ready = 1'b1;
    seed_load(32'd3);
    in_enable = 1'b1;
    for (int round = 0; round < 4; round++) begin
      t = model_total();
      for (int n = 0; n < ((round == 0) ? 5 : 2 * t + 1); n++) begin
        wait_valid(lat, dl, to);
        det_expect(exp);
        n_tests++;
        if (to || out_segment_number !== 2'(exp) || lat != exp + 4) begin
          n_fail++;
          $display("FAIL det_weights[%0d.%0d]: got seg %0d lat %0d expected seg %0d lat %0d",
                   round, n, out_segment_number, lat, exp, exp + 4);
        end
      end
      if (round == 0) set_weights(1, 1, 0, 0);
      else begin
        do set_weights($urandom_range(0, 5), $urandom_range(0, 5),
                       $urandom_range(0, 5), $urandom_range(0, 5));
        while (model_total() == 0);
      end
    end
  endtask

  task automatic test_random_dist();
    int lat, exp, mism, cnt[NS];
    logic [31:0] dl;
    bit to;
    set_weights(2, 4, 2, 0);
    in_mode = 1'b0; in_ready = 1'b1;
    seed_load(32'd1);
    in_enable = 1'b1;
    mism = 0;
    for (int i = 0; i < NS; i++) cnt[i] = 0;
    for (int n = 0; n < 8000; n++) begin
      wait_valid(lat, dl, to);
      exp = rand_seg(dl);
      if (to || out_segment_number !== 2'(exp) || lat != exp + 4) mism++;
      seq[n] = int'(out_segment_number);
      cnt[out_segment_number]++;
    end
    n_tests++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL rand_model: got %0d mismatching results expected 0", mism);
    end
    n_tests++;
    if (cnt[0] < 1900 || cnt[0] > 2100) begin
      n_fail++;
      $display("FAIL rand_count0: got %0d expected 1900..2100", cnt[0]);
    end
    n_tests++;
    if (cnt[1] < 3800 || cnt[1] > 4200) begin
      n_fail++;
      $display("FAIL rand_count1: got %0d expected 3800..4200", cnt[1]);
    end
    n_tests++;
    if (cnt[2] < 1900 || cnt[2] > 2100) begin
      n_fail++;
      $display("FAIL rand_count2: got %0d expected 1900..2100", cnt[2]);
    end
    n_tests++;
    if (cnt[3] != 0) begin
      n_fail++;
      $display("FAIL rand_count3: got %0d expected 0", cnt[3]);
    end
    seed_load(32'd1);
    in_enable = 1'b1;
    mism = 0;
    for (int n = 0; n < 500; n++) begin
      wait_valid(lat, dl, to);
      if (to || int'(out_segment_number) != seq[n]) mism++;
    end
    n_tests++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL rand_repeat: got %0d differing results expected 0", mism);
    end
  endtask

  task automatic test_random_weights();
    int lat, exp, mism;
    logic [31:0] dl;
    bit to;
    in_mode = 1'b0; in_ready = 1'b1;
    for (int round = 0; round < 3; round++) begin
      do set_weights($urandom_range(0, 8191), $urandom_range(0, 8191),
                     $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 8191),
                     $urandom_range(0, 8191));
      while (model_total() == 0);
      seed_load($urandom);
      in_enable = 1'b1;
      mism = 0;
      for (int n = 0; n < 200; n++) begin
        wait_valid(lat, dl, to);
        exp = rand_seg(dl);
        if (to || out_segment_number !== 2'(exp) || lat != exp + 4) mism++;
      end
      n_tests++;
      if (mism != 0) begin
        n_fail++;
        $display("FAIL rand_weights[%0d]: got %0d mismatching results expected 0", round, mism);
      end
    end
  endtask

  task automatic test_seed_zero();
    int lat, mism, first[20];
    logic [31:0] dl;
    bit to;
    set_weights(5, 1, 3, 7);
    in_mode = 1'b0; in_ready = 1'b1;
    seed_load(32'd0);
    in_enable = 1'b1;
    mism = 0;
    for (int n = 0; n < 20; n++) begin
      wait_valid(lat, dl, to);
      if (to || out_segment_number !== 2'(rand_seg(dl))) mism++;
      first[n] = int'(out_segment_number);
    end
    n_tests++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL seed_zero_model: got %0d mismatching results expected 0", mism);
    end
    seed_load(32'd1);
    in_enable = 1'b1;
    mism = 0;
    for (int n = 0; n < 20; n++) begin
      wait_valid(lat, dl, to);
      if (to || int'(out_segment_number) != first[n]) mism++;
    end
    n_tests++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL seed_zero_as_one: got %0d differing results expected 0", mism);
    end
  endtask

  task automatic test_zero_weights();
    set_weights(0, 0, 0, 0);
    in_ready = 1'b0;
    seed_load(32'd9);
    in_enable = 1'b1;
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_early_valid: got %0b expected 0", out_valid);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_none !== 1'b1 || out_segment_number !== 2'd0) begin
      n_fail++;
      $display("FAIL zero_result: got valid=%0b none=%0b seg=%0d expected 1 1 0",
               out_valid, out_none, out_segment_number);
    end
    in_ready = 1'b1;
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || out_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_transfer: got valid=%0b busy=%0b expected 0 1", out_valid, out_busy);
    end
  endtask

  task automatic test_ready_stall();
    int lat, exp, bad;
    logic [31:0] dl;
    bit to;
    set_weights(0, 3, 1, 0);
    in_mode = 1'b1; in_ready = 1'b0;
    seed_load(32'd5);
    in_enable = 1'b1;
    wait_valid(lat, dl, to);
    det_expect(exp);
    n_tests++;
    if (to || out_segment_number !== 2'(exp)) begin
      n_fail++;
      $display("FAIL stall_first: got %0d expected %0d", out_segment_number, exp);
    end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid !== 1'b1 || out_segment_number !== 2'(exp) ||
          out_none !== 1'b0 || out_busy !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad);
    end
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_one_transfer: got valid=%0b expected 0", out_valid);
    end
    for (int n = 0; n < 3; n++) begin
      wait_valid(lat, dl, to);
      det_expect(exp);
      in_ready = 1'b1;
      n_tests++;
      if (to || out_segment_number !== 2'(exp)) begin
        n_fail++;
        $display("FAIL stall_next[%0d]: got %0d expected %0d", n, out_segment_number, exp);
      end
    end
  endtask

  task automatic test_seed_during_scan();
    int lat, exp;
    logic [31:0] dl;
    bit to;
    set_weights(2, 4, 2, 0);
    in_mode = 1'b1; in_ready = 1'b1;
    seed_load(32'd11);
    in_enable = 1'b1;
    for (int n = 0; n < 3; n++) begin
      wait_valid(lat, dl, to);
      det_expect(exp);
    end
    tick(); tick(); tick();
    n_tests++;
    if (out_busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_pre_scan: got busy=%0b valid=%0b expected 1 0", out_busy, out_valid);
    end
    seed_load($urandom);
    n_tests++;
    if (out_valid !== 1'b0 || out_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got valid=%0b busy=%0b expected 0 0", out_valid, out_busy);
    end
    in_enable = 1'b1;
    for (int n = 0; n < 3; n++) begin
      wait_valid(lat, dl, to);
      det_expect(exp);
      n_tests++;
      if (to || out_segment_number !== 2'(exp)) begin
        n_fail++;
        $display("FAIL abort_restart[%0d]: got %0d expected %0d", n, out_segment_number, exp);
      end
    end
  endtask

  task automatic test_enable_freeze();
    int lat, exp, bad, cnt;
    logic [31:0] snap, dl;
    bit to;
    set_weights(1, 2, 3, 10);
    in_mode = 1'b0; in_ready = 1'b1;
    seed_load($urandom);
    in_enable = 1'b1;
    tick(); tick();
    snap = m_lfsr;
    tick();
    exp = rand_seg(snap);
    in_enable = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (out_valid !== 1'b0 || out_busy !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL freeze_hold: got %0d bad cycles expected 0", bad);
    end
    in_enable = 1'b1;
    cnt = 0;
    do begin tick(); cnt++; end while (!out_valid && cnt < 40);
    n_tests++;
    if (!out_valid || out_segment_number !== 2'(exp) || cnt != exp + 1) begin
      n_fail++;
      $display("FAIL freeze_resume: got seg %0d after %0d edges expected seg %0d after %0d",
               out_segment_number, cnt, exp, exp + 1);
    end
    wait_valid(lat, dl, to);
    exp = rand_seg(dl);
    n_tests++;
    if (to || out_segment_number !== 2'(exp)) begin
      n_fail++;
      $display("FAIL freeze_next: got %0d expected %0d", out_segment_number, exp);
    end
  endtask

  task automatic test_async_reset();
    int lat, exp;
    logic [31:0] dl;
    bit to;
    set_weights(2, 4, 2, 0);
    in_mode = 1'b1; in_ready = 1'b1;
    seed_load(32'd13);
    in_enable = 1'b1;
    for (int n = 0; n < 7; n++) begin
      wait_valid(lat, dl, to);
      det_expect(exp);
    end
    tick(); tick(); tick();
    n_tests++;
    if (out_segment_number !== 2'(exp) || out_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: got seg=%0d busy=%0b expected %0d 1", out_segment_number, out_busy, exp);
    end
    #2 in_reset = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, out_segment_number, out_none, out_busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL areset_outputs: got valid=%0b seg=%0d none=%0b busy=%0b expected all 0",
               out_valid, out_segment_number, out_none, out_busy);
    end
    #2 in_reset = 1'b1;
    m_lfsr = 32'd1;
    det_p  = 0;
    wait_valid(lat, dl, to);
    det_expect(exp);
    n_tests++;
    if (to || out_segment_number !== 2'(exp)) begin
      n_fail++;
      $display("FAIL areset_restart: got %0d expected %0d", out_segment_number, exp);
    end
  endtask

  initial begin
    test_reset();
    test_deterministic();
    test_det_weights();
    test_zero_weights();
    test_ready_stall();
    test_seed_during_scan();
    test_enable_freeze();
    test_seed_zero();
    test_random_weights();
    test_async_reset();
    test_random_dist();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
